palette_regs: RTL and testbench
===============================

PALETTE_REGS -- requirements
Module: palette_regs

Interface
REQ-001 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-002 SHALL have port reset, input, 1, synchronous active-high reset, sampled on the clk rising edge.
REQ-003 SHALL have port cpu_din, input, 8, the CPU write data byte.
REQ-004 SHALL have port wr_ptr, input, 1, a one-cycle strobe that writes the palette pointer from cpu_din[3:0].
REQ-005 SHALL have port wr_data, input, 1, a one-cycle strobe that writes one palette data byte from cpu_din.
REQ-006 SHALL have port color, input, 4, the TI99 color index presented by the pixel pipeline.
REQ-007 SHALL have ports red, grn and blu, output, 2 each, the registered 6-bit DAC value for color.

Function
REQ-008 SHALL hold 16 entries of {red[1:0], grn[1:0], blu[1:0]}, a 4-bit pointer ptr and a 1-bit byte phase.
REQ-009 SHALL update red/grn/blu every cycle with entry[color], 1-cycle latency.
REQ-010 SHALL, on wr_ptr, load ptr from cpu_din[3:0] and force phase to 0; cpu_din[7:4] SHALL be ignored.
REQ-011 SHALL, on wr_data with phase 0:
- latch the held red from cpu_din[5:4] and the held blu from cpu_din[1:0]
- set phase to 1
- leave the entry array unchanged
REQ-012 SHALL, on wr_data with phase 1:
- write entry[ptr] = {held red, cpu_din[1:0], held blu} in a single cycle
- set phase to 0
- increment ptr, wrapping 15 to 0
REQ-013 SHALL give wr_ptr priority when wr_ptr and wr_data are asserted in the same cycle; that wr_data SHALL be discarded with no phase change.
REQ-014 SHALL, when entry[color] is written in the same cycle color selects it, output the old value that cycle and the new value from the next cycle.
REQ-015 SHALL ignore unused cpu_din bits in data bytes, which have no effect.
REQ-016 SHALL accept back-to-back strobes on consecutive cycles with no wait states.

Reset
REQ-017 SHALL, while reset is asserted:
- set ptr = 0, phase = 0 and the held red/blu = 0
- set red/grn/blu = 0
- load all 16 entries with the default TI99 table (REQ-024)
REQ-018 SHALL let reset override all strobes in the same cycle; a half-written pair (phase 1) SHALL be abandoned with no entry changed.
REQ-019 SHALL output the default value for color from the first cycle after reset deasserts.

Configuration
REQ-020 SHALL, with PALETTE_READBACK_EN defined, add port rd_data (input, 1, CPU read strobe) and port cpu_dout (output, 8, registered read data, reset 0).
REQ-021 SHALL, on rd_data with PALETTE_READBACK_EN defined:
- phase 0: cpu_dout = {2'b0, red, 2'b0, blu} of entry[ptr]
- phase 1: cpu_dout = {6'b0, grn} of entry[ptr]
- cpu_dout valid the next cycle
- advance phase and ptr exactly as wr_data does, with no entry write
REQ-022 SHALL resolve simultaneous strobes in priority order wr_ptr, then wr_data, then rd_data; lower-priority strobes are ignored.
REQ-023 SHALL, without PALETTE_READBACK_EN, have neither rd_data nor cpu_dout, and otherwise behave identically.

Structure
REQ-024 SHALL take from shared package vdp_pkg:
- the 16-entry default palette constant (0/1 black 000000; 2 0/2/0; 3 0/3/0; 4 0/0/1; 5 0/0/3; 6 1/0/0; 7 0/3/3; 8 2/0/0; 9 3/0/0; A 1/1/0; B 3/3/0; C 0/1/0; D 3/0/3; E 1/1/1; F 3/3/3)
- the rgb entry typedef
- the data-byte field positions
REQ-025 SHALL be a single module with no sub-module; the entry array is flop-based.

Verification
REQ-026 SHALL pass a reset check: after reset, sweep color 0..F -> outputs match the default table one cycle later (e.g. 9 -> 3/0/0).
REQ-027 SHALL pass a single write: wr_ptr 0x05, wr_data 0x21, wr_data 0x02 -> entry 5 = 2/2/1, ptr = 6; color=5 next cycle -> 2/2/1.
REQ-028 SHALL pass a wrap-around: wr_ptr 0x0F, then four data bytes 0x30, 0x00, 0x03, 0x03 -> entry F = 3/0/0, entry 0 = 0/3/3, ptr = 1.
REQ-029 SHALL pass a collision: wr_ptr and wr_data in the same cycle with din 0x07 -> ptr = 7, phase 0, no entry changed.
REQ-030 SHALL pass a reset mid-pair: wr_ptr 2, wr_data 0x33, reset -> entry 2 = 0/2/0 (default), phase 0.
REQ-031 SHALL pass a readback with PALETTE_READBACK_EN defined: wr_ptr 0x0D, rd_data, rd_data -> cpu_dout 0x33 then 0x00, ptr = 0xE.

Source files
------------

// File: rtl/vdp_pkg.sv
// Shared VDP definitions: palette entry type, CPU data-byte field positions, TI99 default palette.
// Latency: none (types, constants and a pure lookup function).
// Backpressure: none.
package vdp_pkg;

  localparam int PAL_ENTRIES = 16;

  // One palette entry: 2 bits each of red, green and blue feeding the DAC.
  typedef struct packed {
    logic [1:0] red;
    logic [1:0] grn;
    logic [1:0] blu;
  } rgb_t;

  // Field positions inside a palette data byte.
  // The first byte of a pair carries red and blue; the second carries green.
  localparam int DIN_RED_MSB = 5;
  localparam int DIN_RED_LSB = 4;
  localparam int DIN_BLU_MSB = 1;
  localparam int DIN_BLU_LSB = 0;
  localparam int DIN_GRN_MSB = 1;
  localparam int DIN_GRN_LSB = 0;

  // Default TI99 colour table, indexed by colour number.
  function automatic rgb_t default_palette(input logic [3:0] idx);
    rgb_t e;
    case (idx)
      4'h0:    e = '{red: 2'd0, grn: 2'd0, blu: 2'd0};
      4'h1:    e = '{red: 2'd0, grn: 2'd0, blu: 2'd0};
      4'h2:    e = '{red: 2'd0, grn: 2'd2, blu: 2'd0};
      4'h3:    e = '{red: 2'd0, grn: 2'd3, blu: 2'd0};
      4'h4:    e = '{red: 2'd0, grn: 2'd0, blu: 2'd1};
      4'h5:    e = '{red: 2'd0, grn: 2'd0, blu: 2'd3};
      4'h6:    e = '{red: 2'd1, grn: 2'd0, blu: 2'd0};
      4'h7:    e = '{red: 2'd0, grn: 2'd3, blu: 2'd3};
      4'h8:    e = '{red: 2'd2, grn: 2'd0, blu: 2'd0};
      4'h9:    e = '{red: 2'd3, grn: 2'd0, blu: 2'd0};
      4'hA:    e = '{red: 2'd1, grn: 2'd1, blu: 2'd0};
      4'hB:    e = '{red: 2'd3, grn: 2'd3, blu: 2'd0};
      4'hC:    e = '{red: 2'd0, grn: 2'd1, blu: 2'd0};
      4'hD:    e = '{red: 2'd3, grn: 2'd0, blu: 2'd3};
      4'hE:    e = '{red: 2'd1, grn: 2'd1, blu: 2'd1};
      default: e = '{red: 2'd3, grn: 2'd3, blu: 2'd3};
    endcase
    return e;
  endfunction

endpackage

// File: rtl/palette_regs.sv
// CPU-programmable 16-entry palette driving a 6-bit DAC; optional readback via PALETTE_READBACK_EN.
// Latency: colour lookup 1 cycle; CPU writes/reads take effect on the strobe edge, readback data next cycle.
// Backpressure: none -- every strobe is accepted on the cycle it is presented, back-to-back allowed.
module palette_regs
  import vdp_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] cpu_din,
  input  logic       wr_ptr,
  input  logic       wr_data,
`ifdef PALETTE_READBACK_EN
  input  logic       rd_data,
  output logic [7:0] cpu_dout,
`endif
  input  logic [3:0] color,
  output logic [1:0] red,
  output logic [1:0] grn,
  output logic [1:0] blu
);

  rgb_t       entry [PAL_ENTRIES];
  logic [3:0] ptr;
  logic       phase;
  logic [1:0] held_red;
  logic [1:0] held_blu;

  // Bits 7:6 of the CPU byte carry no meaning in any transfer.
  logic unused_din;
  assign unused_din = ^cpu_din[7:6];

  // Colour lookup: the entry array is read before this cycle's write lands,
  // so a same-cycle write to the selected entry shows up one cycle later.
  always_ff @(posedge clk) begin
    if (reset) begin
      red <= 2'd0;
      grn <= 2'd0;
      blu <= 2'd0;
    end else begin
      red <= entry[color].red;
      grn <= entry[color].grn;
      blu <= entry[color].blu;
    end
  end

  // CPU side: pointer load beats data write, which beats readback.
  // A data pair is red/blue first (held), then green commits the whole entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < PAL_ENTRIES; i++) begin
        entry[i] <= default_palette(i[3:0]);
      end
      ptr      <= 4'd0;
      phase    <= 1'b0;
      held_red <= 2'd0;
      held_blu <= 2'd0;
    end else if (wr_ptr) begin
      ptr   <= cpu_din[3:0];
      phase <= 1'b0;
    end else if (wr_data) begin
      if (!phase) begin
        held_red <= cpu_din[DIN_RED_MSB:DIN_RED_LSB];
        held_blu <= cpu_din[DIN_BLU_MSB:DIN_BLU_LSB];
        phase    <= 1'b1;
      end else begin
        entry[ptr] <= '{red: held_red,
                        grn: cpu_din[DIN_GRN_MSB:DIN_GRN_LSB],
                        blu: held_blu};
        phase      <= 1'b0;
        ptr        <= ptr + 4'd1;
      end
    end
`ifdef PALETTE_READBACK_EN
    else if (rd_data) begin
      // Reads walk the same pointer/phase sequence as writes.
      phase <= ~phase;
      if (phase) begin
        ptr <= ptr + 4'd1;
      end
    end
`endif
  end

`ifdef PALETTE_READBACK_EN
  // Readback register: only a read that wins priority updates it.
  always_ff @(posedge clk) begin
    if (reset) begin
      cpu_dout <= 8'h00;
    end else if (rd_data && !wr_ptr && !wr_data) begin
      if (!phase) begin
        cpu_dout <= {2'b00, entry[ptr].red, 2'b00, entry[ptr].blu};
      end else begin
        cpu_dout <= {6'b000000, entry[ptr].grn};
      end
    end
  end
`endif

endmodule

// File: tb/tb_palette_regs.sv
// Self-checking bench for palette_regs: randomized CPU/pixel traffic against a table-level model.
// Latency: model predicts the DAC value one cycle after each driven cycle.
// Backpressure: none; a monitor pops one expectation per clock.
module tb_palette_regs;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] cpu_din;
  logic       wr_ptr;
  logic       wr_data;
  logic       rd_data;
  logic [3:0] color;
  logic [1:0] red, grn, blu;
`ifdef PALETTE_READBACK_EN
  logic [7:0] cpu_dout;
`endif

  always #5 clk = ~clk;

  palette_regs dut (
    .clk     (clk),
    .reset   (reset),
    .cpu_din (cpu_din),
    .wr_ptr  (wr_ptr),
    .wr_data (wr_data),
`ifdef PALETTE_READBACK_EN
    .rd_data (rd_data),
    .cpu_dout(cpu_dout),
`endif
    .color   (color),
    .red     (red),
    .grn     (grn),
    .blu     (blu)
  );

  // Reference model: palette as {r,g,b} 6-bit words plus pointer state.
  logic [5:0] def_tab [16];
  logic [5:0] pal [16];
  logic [3:0] m_ptr;
  logic       m_phase;
  logic [1:0] m_hr, m_hb;
  logic [7:0] m_dout;

  typedef struct {
    logic [5:0] rgb;
    logic [7:0] dout;
    string      tag;
  } exp_t;
  exp_t exp_q[$];

  int total = 0;
  int bad   = 0;
  string cur_tag = "init";

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%02h expected 0x%02h at %0t", name, act, req, $time);
    end
  endtask

  // Drive one cycle at the falling edge and record what the DUT must show after the next rising edge.
  task automatic step(input bit rst, input bit wp, input bit wd, input bit rd,
                      input logic [7:0] din, input logic [3:0] col);
    exp_t e;
    @(negedge clk);
    reset   = rst;
    wr_ptr  = wp;
    wr_data = wd;
    rd_data = rd;
    cpu_din = din;
    color   = col;
    e.rgb = rst ? 6'd0 : pal[col];
    if (rst) begin
      for (int i = 0; i < 16; i++) pal[i] = def_tab[i];
      m_ptr = 4'd0; m_phase = 1'b0; m_hr = 2'd0; m_hb = 2'd0; m_dout = 8'h00;
    end else if (wp) begin
      m_ptr = din[3:0];
      m_phase = 1'b0;
    end else if (wd) begin
      if (!m_phase) begin
        m_hr = din[5:4];
        m_hb = din[1:0];
        m_phase = 1'b1;
      end else begin
        pal[m_ptr] = {m_hr, din[1:0], m_hb};
        m_phase = 1'b0;
        m_ptr = m_ptr + 4'd1;
      end
    end else if (rd) begin
`ifdef PALETTE_READBACK_EN
      if (!m_phase) begin
        m_dout = {2'b00, pal[m_ptr][5:4], 2'b00, pal[m_ptr][1:0]};
        m_phase = 1'b1;
      end else begin
        m_dout = {6'd0, pal[m_ptr][3:2]};
        m_phase = 1'b0;
        m_ptr = m_ptr + 4'd1;
      end
`endif
    end
    e.dout = m_dout;
    e.tag  = cur_tag;
    exp_q.push_back(e);
  endtask

  task automatic idle(input logic [3:0] col);
    step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, col);
  endtask

  // After an idle step all earlier cycles have committed in the DUT.
  task automatic check_state(input string name);
    check({name, "_ptr"}, {4'd0, dut.ptr}, {4'd0, m_ptr});
    check({name, "_phase"}, {7'd0, dut.phase}, {7'd0, m_phase});
  endtask

  // Monitor: the DAC output is valid every cycle; compare one expectation per clock.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check({e.tag, "_rgb"}, {2'b00, red, grn, blu}, {2'b00, e.rgb});
`ifdef PALETTE_READBACK_EN
        check({e.tag, "_dout"}, cpu_dout, e.dout);
`endif
      end
    end
  end

  initial begin
    def_tab = '{6'b000000, 6'b000000, 6'b001000, 6'b001100,
                6'b000001, 6'b000011, 6'b010000, 6'b001111,
                6'b100000, 6'b110000, 6'b010100, 6'b111100,
                6'b000100, 6'b110011, 6'b010101, 6'b111111};
    for (int i = 0; i < 16; i++) pal[i] = def_tab[i];
    m_ptr = 4'd0; m_phase = 1'b0; m_hr = 2'd0; m_hb = 2'd0; m_dout = 8'h00;
    reset = 1'b1; wr_ptr = 1'b0; wr_data = 1'b0; rd_data = 1'b0;
    cpu_din = 8'h00; color = 4'h0;

    // Reset, then sweep the default table.
    cur_tag = "reset";
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 4'($urandom_range(15)));
    cur_tag = "default_sweep";
    for (int i = 0; i < 16; i++) idle(4'(i));
    check_state("after_reset");

    // Single write to entry 5.
    cur_tag = "single_write";
    step(1'b0, 1'b1, 1'b0, 1'b0, 8'h05, 4'h5);
    step(1'b0, 1'b0, 1'b1, 1'b0, 8'h21, 4'h5);
    step(1'b0, 1'b0, 1'b1, 1'b0, 8'h02, 4'h5);   // same-cycle read of entry 5 sees old value
    idle(4'h5);
    check_state("single_write");
    idle(4'h5);

    // Wrap from entry F to entry 0.
    cur_tag = "wrap";
    step(1'b0, 1'b1, 1'b0, 1'b0, 8'h0F, 4'hF);
    step(1'b0, 1'b0, 1'b1, 1'b0, 8'h30, 4'hF);
    step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 4'hF);
    step(1'b0, 1'b0, 1'b1, 1'b0, 8'h03, 4'h0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 8'h03, 4'h0);
    idle(4'hF);
    check_state("wrap");
    idle(4'h0);

    // Pointer strobe beats data strobe.
    cur_tag = "collision";
    step(1'b0, 1'b0, 1'b1, 1'b0, 8'h12, 4'h3);   // leave phase at 1 first
    step(1'b0, 1'b1, 1'b1, 1'b0, 8'h07, 4'h7);
    idle(4'h7);
    check_state("collision");

    // Reset abandons a half-written pair.
    cur_tag = "reset_mid_pair";
    step(1'b0, 1'b1, 1'b0, 1'b0, 8'h02, 4'h2);
    step(1'b0, 1'b0, 1'b1, 1'b0, 8'h33, 4'h2);
    step(1'b1, 1'b0, 1'b1, 1'b0, 8'h33, 4'h2);
    idle(4'h2);
    check_state("reset_mid_pair");
    idle(4'h2);

`ifdef PALETTE_READBACK_EN
    cur_tag = "readback";
    step(1'b0, 1'b1, 1'b0, 1'b0, 8'h0D, 4'hD);
    step(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 4'hD);
    step(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 4'hD);
    idle(4'hD);
    check_state("readback");
    step(1'b0, 1'b0, 1'b1, 1'b1, 8'h11, 4'h1);   // data beats read
`endif

    // Randomized traffic, including back-to-back strobes and occasional reset.
    cur_tag = "random";
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(63) == 0), ($urandom_range(7) == 0), ($urandom_range(2) == 0),
           ($urandom_range(3) == 0), 8'($urandom), 4'($urandom));
      if (i % 50 == 49) begin
        idle(4'($urandom));
        check_state("random");
      end
    end
    cur_tag = "final_sweep";
    for (int i = 0; i < 16; i++) idle(4'(i));

    // Drain the scoreboard with a bounded wait.
    begin
      int n = 0;
      while (exp_q.size() > 0 && n < 20) begin
        @(posedge clk);
        n++;
      end
      #2;
      if (exp_q.size() > 0) begin
        total++;
        bad++;
        $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
